pulse_train_sched: RTL and testbench
====================================

PULSE_TRAIN_SCHED -- requirements
Module: pulse_train_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the pulse output (2..8).
REQ-002 Parameter PW, default 4: width of per-requester pulses-per-set field.
REQ-003 Parameter SW, default 2: width of per-requester sets-per-burst and gap fields.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  NREQ  per-requester burst request, level-sensitive.
REQ-007 cfg_pulses  input  NREQ*PW  pulses per set for requester i, slice [i*PW +: PW].
REQ-008 cfg_sets  input  NREQ*SW  sets per burst for requester i, slice [i*SW +: SW].
REQ-009 cfg_gap  input  NREQ*SW  low cycles between sets for requester i, slice [i*SW +: SW].
REQ-010 abort  input  1  terminate the current burst.
REQ-011 grant  output  NREQ  one-hot owner of the pulse output; all-zero when idle.
REQ-012 pulse  output  1  registered pulse train.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  NREQ  one-cycle completion strobe to the granted requester.

Function
REQ-015 States: IDLE, LOAD, HIGH, LOW, GAP, DONE; pulse=1 only in HIGH.
REQ-016 IDLE: when any req bit is high at a clock edge, go to LOAD; the winner is selected round-robin starting at pointer rr_ptr.
REQ-017 LOAD (1 cycle): grant one-hot set to the winner; winner's cfg_pulses/cfg_sets/cfg_gap latched; later cfg changes ignored until the next LOAD.
REQ-018 LOAD exit: to DONE if latched pulses==0 or sets==0 (no pulse emitted); otherwise to HIGH.
REQ-019 HIGH (1 cycle) always goes to LOW; the pulse counter increments on leaving HIGH.
REQ-020 LOW exit: to HIGH if pulses-in-set < latched pulses; at end of set, to DONE if last set, else to GAP if gap>0, else to HIGH; the set counter increments at end of set.
REQ-021 GAP lasts exactly latched gap cycles, then goes to HIGH with the pulse counter cleared.
REQ-022 No gap follows the last set.
REQ-023 Burst length from LOAD to DONE inclusive is 2 + S*2P + (S-1)*G cycles.
REQ-024 DONE (1 cycle): done[owner]=1; grant held; rr_ptr = owner+1 mod NREQ; next state IDLE.
REQ-025 In IDLE, grant is all-zero.
REQ-026 A new request can win in the IDLE cycle following DONE; there are no back-to-back grants without IDLE.
REQ-027 Deassertion of the owner's req mid-burst is ignored; the burst completes.
REQ-028 abort high in LOAD/HIGH/LOW/GAP:
  - next state IDLE; grant cleared and pulse=0 on that edge;
  - no done strobe;
  - rr_ptr = owner+1.
REQ-029 abort is ignored in IDLE and DONE.
REQ-030 Counters are sized to hold the max field value without wrap; comparisons are unsigned.

Reset
REQ-031 Asynchronous reset forces state=IDLE, grant=0, pulse=0, busy=0, done=0, rr_ptr=0, and all counters and latched config to 0.
REQ-032 Reset asserted mid-burst truncates the burst immediately, with no done strobe.
REQ-033 After reset deasserts, the first clock edge with req high enters LOAD.

Structure
REQ-034 Package pulse_sched_pkg holds the state encoding constants and default PW/SW/NREQ values.
REQ-035 Sub-module rr_arbiter (inputs req and rr_ptr, outputs one-hot winner) is combinational and shared with future schedulers.
REQ-036 The FSM, counters, and config latches reside in pulse_train_sched.

Verification
REQ-037 Single burst: req[0] with P=3, S=2, G=2, sampled at edge 0.
  - pulse high in cycles 1, 3, 5, 9, 11, 13;
  - done[0] in cycle 15; busy cycles 0..15.
REQ-038 Fairness: req[0] and req[2] held high from reset with P=1, S=1, G=0.
  - grants alternate 0, 2, 0, 2; each burst is 4 cycles plus 1 IDLE.
REQ-039 Zero config: req[1] with P=0.
  - LOAD then DONE; done[1] pulses; pulse never high; rr_ptr=2.
REQ-040 Abort: assert abort in the second HIGH of a P=4 burst.
  - next cycle IDLE, grant=0, pulse=0, no done; the next grant goes to owner+1.
REQ-041 Reset mid-GAP: all outputs 0 asynchronously.
  - after release, req[3] is granted with a fresh config latch.
REQ-042 Config change: alter cfg_pulses[0] during the burst.
  - pulse count equals the value latched at LOAD.

Source files
------------

// File: rtl/pulse_sched_pkg.sv
// Shared state encoding and default sizing for the pulse-train scheduler family.
package pulse_sched_pkg;

    localparam int NREQ_DEF = 4;
    localparam int PW_DEF   = 4;
    localparam int SW_DEF   = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_HIGH = 3'd2,
        ST_LOW  = 3'd3,
        ST_GAP  = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    // States in which an abort terminates the burst.
    function automatic logic is_abortable(input state_e s);
        return (s == ST_LOAD) || (s == ST_HIGH) || (s == ST_LOW) || (s == ST_GAP);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after rr_ptr wins.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PTRW-1:0] rr_ptr,
    output logic [NREQ-1:0] gnt
);

    logic found;
    int   idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pulse_train_sched.sv
// Shares one registered pulse output between NREQ requesters; each granted
// burst is S sets of P one-cycle pulses separated by G low cycles.
module pulse_train_sched
    import pulse_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int PW   = PW_DEF,
    parameter int SW   = SW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*PW-1:0] cfg_pulses,
    input  logic [NREQ*SW-1:0] cfg_sets,
    input  logic [NREQ*SW-1:0] cfg_gap,
    input  logic              abort,
    output logic [NREQ-1:0]   grant,
    output logic              pulse,
    output logic              busy,
    output logic [NREQ-1:0]   done
);

    localparam int PTRW = $clog2(NREQ);

    state_e            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              pulse_q, pulse_d;
    logic              busy_q,  busy_d;
    logic [NREQ-1:0]   done_q,  done_d;
    logic [PTRW-1:0]   ptr_q,   ptr_d;
    logic [PTRW-1:0]   owner_q, owner_d;
    logic [PW-1:0]     p_lat_q, p_lat_d;
    logic [SW-1:0]     s_lat_q, s_lat_d;
    logic [SW-1:0]     g_lat_q, g_lat_d;
    logic [PW-1:0]     pcnt_q,  pcnt_d;
    logic [SW-1:0]     scnt_q,  scnt_d;
    logic [SW-1:0]     gcnt_q,  gcnt_d;

    logic [NREQ-1:0]   win;
    logic [PTRW-1:0]   win_idx;
    logic [PTRW-1:0]   nxt_ptr;
    logic              last_set;
    logic              gap_end;

    rr_arbiter #(.NREQ(NREQ), .PTRW(PTRW)) u_arb (
        .req    (req),
        .rr_ptr (ptr_q),
        .gnt    (win)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) win_idx = PTRW'(i);
        end
    end

    assign nxt_ptr  = (owner_q == PTRW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    // Widened by one bit so S or G at full field value cannot wrap the compare.
    assign last_set = (({1'b0, scnt_q} + 1'b1) == {1'b0, s_lat_q});
    assign gap_end  = (({1'b0, gcnt_q} + 1'b1) == {1'b0, g_lat_q});

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        pulse_d = 1'b0;
        done_d  = '0;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        p_lat_d = p_lat_q;
        s_lat_d = s_lat_q;
        g_lat_d = g_lat_q;
        pcnt_d  = pcnt_q;
        scnt_d  = scnt_q;
        gcnt_d  = gcnt_q;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_LOAD;
                    grant_d = win;
                    owner_d = win_idx;
                    p_lat_d = cfg_pulses[win_idx*PW +: PW];
                    s_lat_d = cfg_sets[win_idx*SW +: SW];
                    g_lat_d = cfg_gap[win_idx*SW +: SW];
                    pcnt_d  = '0;
                    scnt_d  = '0;
                    gcnt_d  = '0;
                end
            end
            ST_LOAD: begin
                if (p_lat_q == '0 || s_lat_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = grant_q;
                end else begin
                    state_d = ST_HIGH;
                    pulse_d = 1'b1;
                end
            end
            ST_HIGH: begin
                state_d = ST_LOW;
                pcnt_d  = pcnt_q + 1'b1;
            end
            ST_LOW: begin
                if (pcnt_q < p_lat_q) begin
                    state_d = ST_HIGH;
                    pulse_d = 1'b1;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                    if (last_set) begin
                        state_d = ST_DONE;
                        done_d  = grant_q;
                    end else if (g_lat_q != '0) begin
                        state_d = ST_GAP;
                        gcnt_d  = '0;
                    end else begin
                        state_d = ST_HIGH;
                        pulse_d = 1'b1;
                        pcnt_d  = '0;
                    end
                end
            end
            ST_GAP: begin
                if (gap_end) begin
                    state_d = ST_HIGH;
                    pulse_d = 1'b1;
                    pcnt_d  = '0;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = '0;
                ptr_d   = nxt_ptr;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        if (abort && is_abortable(state_q)) begin
            state_d = ST_IDLE;
            grant_d = '0;
            pulse_d = 1'b0;
            done_d  = '0;
            ptr_d   = nxt_ptr;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            p_lat_q <= '0;
            s_lat_q <= '0;
            g_lat_q <= '0;
            pcnt_q  <= '0;
            scnt_q  <= '0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            p_lat_q <= p_lat_d;
            s_lat_q <= s_lat_d;
            g_lat_q <= g_lat_d;
            pcnt_q  <= pcnt_d;
            scnt_q  <= scnt_d;
            gcnt_q  <= gcnt_d;
        end
    end

    assign grant = grant_q;
    assign pulse = pulse_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_pulse_train_sched.sv
// Bench for pulse_train_sched: directed table, corner sequences, and random
// traffic scored against a burst-level reference model.
module tb_pulse_train_sched;

    localparam int NREQ = 4;
    localparam int PW   = 4;
    localparam int SW   = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*PW-1:0]   cfg_pulses = '0;
    logic [NREQ*SW-1:0]   cfg_sets = '0;
    logic [NREQ*SW-1:0]   cfg_gap = '0;
    logic                 abort = 1'b0;
    logic [NREQ-1:0]      grant;
    logic                 pulse;
    logic                 busy;
    logic [NREQ-1:0]      done;

    pulse_train_sched #(.NREQ(NREQ), .PW(PW), .SW(SW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .cfg_pulses (cfg_pulses),
        .cfg_sets   (cfg_sets),
        .cfg_gap    (cfg_gap),
        .abort      (abort),
        .grant      (grant),
        .pulse      (pulse),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int i, input int p, input int s, input int g);
        cfg_pulses[i*PW +: PW] = PW'(p);
        cfg_sets[i*SW +: SW]   = SW'(s);
        cfg_gap[i*SW +: SW]    = SW'(g);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        abort = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // Steps until a done strobe (or the bound runs out), counting pulses.
    task automatic run_until_done(input int maxc, output int npulse, output int ncyc,
                                  output logic [NREQ-1:0] dval);
        npulse = 0;
        ncyc   = -1;
        dval   = '0;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (pulse) npulse++;
            if (done != '0) begin
                ncyc = i + 1;
                dval = done;
                break;
            end
        end
    endtask

    // Burst-level reference: a burst is a fixed pulse pattern of m_len cycles
    // whose last cycle carries the done strobe.
    int m_busy, m_owner, m_t, m_len, m_ptr;
    bit m_pat[128];

    function automatic void m_build(input int p, input int s, input int g);
        for (int i = 0; i < 128; i++) m_pat[i] = 1'b0;
        if (p == 0 || s == 0) begin
            m_len = 2;
        end else begin
            m_len = 2 + s * 2 * p + (s - 1) * g;
            for (int k = 0; k < s; k++)
                for (int o = 0; o < 2 * p; o += 2)
                    m_pat[1 + k * (2 * p + g) + o] = 1'b1;
        end
    endfunction

    task automatic m_edge();
        int w;
        if (m_busy == 0) begin
            if (req != '0) begin
                w = -1;
                for (int k = 0; k < NREQ; k++)
                    if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                m_owner = w;
                m_build(int'(cfg_pulses[w*PW +: PW]), int'(cfg_sets[w*SW +: SW]),
                        int'(cfg_gap[w*SW +: SW]));
                m_t    = 0;
                m_busy = 1;
            end
        end else if (m_t == m_len - 1 || abort) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % NREQ;
        end else begin
            m_t++;
        end
    endtask

    typedef struct {
        logic [NREQ-1:0] req;
        logic            abort;
        logic            pulse;
        logic            busy;
        logic [NREQ-1:0] done;
        logic [NREQ-1:0] grant;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int np, nc, pulses_seen;
        logic [NREQ-1:0] dv;
        logic [NREQ-1:0] exp_g;

        // Reset state, observed while reset is held.
        step();
        chk("rst grant", 32'(grant), 0);
        chk("rst pulse", 32'(pulse), 0);
        chk("rst busy",  32'(busy),  0);
        chk("rst done",  32'(done),  0);

        // Single burst P=3 S=2 G=2 on requester 0.
        for (int c = 0; c < 18; c++) begin
            tbl[c].req   = (c == 0) ? 4'b0001 : 4'b0000;
            tbl[c].abort = 1'b0;
            tbl[c].pulse = (c inside {1, 3, 5, 9, 11, 13});
            tbl[c].busy  = (c <= 15);
            tbl[c].done  = (c == 15) ? 4'b0001 : 4'b0000;
            tbl[c].grant = (c <= 15) ? 4'b0001 : 4'b0000;
        end
        set_cfg(0, 3, 2, 2);
        do_reset();
        for (int c = 0; c < 18; c++) begin
            req   = tbl[c].req;
            abort = tbl[c].abort;
            step();
            chk($sformatf("burst c%0d pulse", c), 32'(pulse), 32'(tbl[c].pulse));
            chk($sformatf("burst c%0d busy", c),  32'(busy),  32'(tbl[c].busy));
            chk($sformatf("burst c%0d done", c),  32'(done),  32'(tbl[c].done));
            chk($sformatf("burst c%0d grant", c), 32'(grant), 32'(tbl[c].grant));
        end

        // Fairness: 0 and 2 held, minimal bursts alternate every 5 cycles.
        set_cfg(0, 1, 1, 0);
        set_cfg(2, 1, 1, 0);
        do_reset();
        req = 4'b0101;
        for (int c = 0; c < 20; c++) begin
            step();
            exp_g = ((c / 5) % 2 == 1) ? 4'b0100 : 4'b0001;
            if (c % 5 == 0) chk($sformatf("fair c%0d grant", c), 32'(grant), 32'(exp_g));
            if (c % 5 == 1) chk($sformatf("fair c%0d pulse", c), 32'(pulse), 1);
            if (c % 5 == 4) chk($sformatf("fair c%0d idle", c), 32'(busy), 0);
        end

        // Zero pulses: LOAD then DONE, pointer moves to 2.
        set_cfg(1, 0, 2, 1);
        set_cfg(3, 0, 0, 0);
        do_reset();
        req = 4'b0010;
        step();
        chk("zero load grant", 32'(grant), 32'(4'b0010));
        chk("zero load pulse", 32'(pulse), 0);
        req = 4'b0000;
        step();
        chk("zero done", 32'(done), 32'(4'b0010));
        chk("zero done pulse", 32'(pulse), 0);
        step();
        chk("zero idle", 32'(busy), 0);
        req = 4'b1011;
        step();
        chk("zero next grant", 32'(grant), 32'(4'b1000));
        req = 4'b0000;
        step();
        step();

        // Abort in the second HIGH of a P=4 burst.
        set_cfg(0, 4, 1, 0);
        set_cfg(1, 0, 0, 0);
        do_reset();
        req = 4'b0001;
        step();
        req = 4'b0000;
        step();
        step();
        step();
        chk("abort 2nd high", 32'(pulse), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort busy",  32'(busy),  0);
        chk("abort grant", 32'(grant), 0);
        chk("abort pulse", 32'(pulse), 0);
        chk("abort done",  32'(done),  0);
        req = 4'b1111;
        step();
        chk("abort next grant", 32'(grant), 32'(4'b0010));
        req = 4'b0000;
        run_until_done(20, np, nc, dv);
        chk("abort next done", 32'(dv), 32'(4'b0010));
        step();

        // Reset asserted in the gap, then a fresh burst for requester 3.
        set_cfg(0, 1, 2, 3);
        do_reset();
        req = 4'b0001;
        step();
        req = 4'b0000;
        step();
        step();
        step();
        chk("gap busy", 32'(busy), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async rst grant", 32'(grant), 0);
        chk("async rst busy",  32'(busy),  0);
        chk("async rst pulse", 32'(pulse), 0);
        chk("async rst done",  32'(done),  0);
        step();
        reset = 1'b0;
        set_cfg(3, 2, 1, 0);
        req = 4'b1000;
        step();
        chk("post rst grant", 32'(grant), 32'(4'b1000));
        req = 4'b0000;
        run_until_done(40, np, nc, dv);
        chk("post rst pulses", 32'(np), 2);
        chk("post rst done", 32'(dv), 32'(4'b1000));
        step();

        // Config altered mid-burst must not affect the latched values.
        set_cfg(0, 2, 1, 0);
        do_reset();
        req = 4'b0001;
        step();
        req = 4'b0000;
        set_cfg(0, 5, 3, 1);
        run_until_done(60, np, nc, dv);
        chk("cfgchg pulses", 32'(np), 2);
        chk("cfgchg done cycle", 32'(nc), 5);
        step();

        // Random traffic against the reference model.
        do_reset();
        m_busy = 0; m_owner = 0; m_t = 0; m_len = 0; m_ptr = 0;
        pulses_seen = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            req        = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
            abort      = ($urandom_range(0, 29) == 0);
            cfg_pulses = 16'($urandom);
            cfg_sets   = 8'($urandom);
            cfg_gap    = 8'($urandom);
            m_edge();
            step();
            chk($sformatf("rnd c%0d busy", cyc), 32'(busy), 32'(m_busy));
            chk($sformatf("rnd c%0d grant", cyc), 32'(grant),
                (m_busy != 0) ? (32'd1 << m_owner) : 32'd0);
            chk($sformatf("rnd c%0d pulse", cyc), 32'(pulse),
                32'((m_busy != 0) && m_pat[m_t]));
            chk($sformatf("rnd c%0d done", cyc), 32'(done),
                (m_busy != 0 && m_t == m_len - 1) ? (32'd1 << m_owner) : 32'd0);
            if (pulse) pulses_seen++;
        end
        req   = '0;
        abort = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
